// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and codes for the hazard stall controller.
// Stall request codes, FSM states and the stall code decoder.
package pipe_stall_ctrl_pkg;

   localparam logic [3:0] PIP_0STOP = 4'd0;
   localparam logic [3:0] PIP_1STOP = 4'd1;
   localparam logic [3:0] PIP_2STOP = 4'd2;
   localparam logic [3:0] PIP_3STOP = 4'd3;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } state_e;

   typedef struct packed {
      logic [1:0] n;
      logic       bad;
   } stall_dec_t;

   function automatic stall_dec_t decode_stall(
      input logic [3:0] code
   );
      stall_dec_t d;
      d.n   = 2'd0;
      d.bad = 1'b0;
      unique case (code)
         PIP_0STOP: d.n = 2'd0;
         PIP_1STOP: d.n = 2'd1;
         PIP_2STOP: d.n = 2'd2;
         PIP_3STOP: d.n = 2'd3;
         default:   d.bad = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Holds at all-ones instead of wrapping.
module pipe_stall_ctrl_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   // count enabled cycles, stick at the top value
   always_ff @(posedge clk) begin
      if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hold/flush controller fed by the hazard detector.
// One posedge FSM counts down multi-cycle RAW stalls.
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int CNT_W  = 2,
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        stall_info,
   input  logic              redirect,
   output logic              pc_we,
   output logic              ifid_we,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              stall_busy,
   output logic [CNT_W-1:0]  stall_left,
   output logic              info_err,
   output logic [PERF_W-1:0] perf_stall,
   output logic [PERF_W-1:0] perf_flush
);

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] left_q;
   logic [CNT_W-1:0] left_d;
   logic             err_q;
   stall_dec_t       dec;

   // translate the hazard code into a stall depth
   always_comb begin
      dec = decode_stall(stall_info);
   end

   // next state and Mealy stage controls
   always_comb begin
      state_d    = state_q;
      left_d     = left_q;
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (redirect) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (dec.n != 2'd0) begin
               pc_we      = 1'b0;
               ifid_we    = 1'b0;
               idex_flush = 1'b1;
               if (dec.n != 2'd1) begin
                  state_d = ST_STALL;
                  left_d  = CNT_W'(dec.n - 2'd1);
               end
            end
         end
         ST_STALL: begin
            if (redirect) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               state_d    = ST_IDLE;
               left_d     = '0;
            end else begin
               pc_we      = 1'b0;
               ifid_we    = 1'b0;
               idex_flush = 1'b1;
               if (left_q == CNT_W'(1)) begin
                  state_d = ST_IDLE;
                  left_d  = '0;
               end else begin
                  left_d = left_q - CNT_W'(1);
               end
            end
         end
      endcase
   end

   // state, countdown and sticky error register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         left_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         left_q  <= left_d;
         err_q   <= err_q | dec.bad;
      end
   end

   assign stall_busy = (state_q == ST_STALL);
   assign stall_left = left_q;
   assign info_err   = err_q;

   pipe_stall_ctrl_sat_counter #(
      .W (PERF_W)
   ) u_perf_stall (
      .clk (clk),
      .clr (rst),
      .en  (~pc_we),
      .cnt (perf_stall)
   );

   pipe_stall_ctrl_sat_counter #(
      .W (PERF_W)
   ) u_perf_flush (
      .clk (clk),
      .clr (rst),
      .en  (ifid_flush),
      .cnt (perf_flush)
   );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed steps then random traffic.
// Reference model tracks remaining stall cycles as a plain integer.
module tb_pipe_stall_ctrl;

   localparam int CNT_W  = 2;
   localparam int PERF_W = 32;

   logic              clk;
   logic              rst;
   logic [3:0]        stall_info;
   logic              redirect;
   logic              pc_we;
   logic              ifid_we;
   logic              ifid_flush;
   logic              idex_flush;
   logic              stall_busy;
   logic [CNT_W-1:0]  stall_left;
   logic              info_err;
   logic [PERF_W-1:0] perf_stall;
   logic [PERF_W-1:0] perf_flush;

   int total;
   int bad;

   int      m_hold;
   bit      m_err;
   longint  m_pstall;
   longint  m_pflush;
   longint  perf_max;

   pipe_stall_ctrl #(
      .CNT_W  (CNT_W),
      .PERF_W (PERF_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall_info (stall_info),
      .redirect   (redirect),
      .pc_we      (pc_we),
      .ifid_we    (ifid_we),
      .ifid_flush (ifid_flush),
      .idex_flush (idex_flush),
      .stall_busy (stall_busy),
      .stall_left (stall_left),
      .info_err   (info_err),
      .perf_stall (perf_stall),
      .perf_flush (perf_flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(
      input string       tag,
      input logic [63:0] obs,
      input logic [63:0] exp
   );
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_hold   = 0;
      m_err    = 1'b0;
      m_pstall = 0;
      m_pflush = 0;
   endtask

   task automatic do_reset(input int cycles);
      rst        = 1'b1;
      stall_info = 4'd0;
      redirect   = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // apply one cycle of inputs, check, then advance the model
   task automatic step(
      input logic [3:0] si,
      input logic       rd
   );
      int n;
      bit illegal;
      bit e_pc;
      bit e_if;
      bit e_iff;
      bit e_idf;
      int nhold;
      stall_info = si;
      redirect   = rd;
      illegal    = (si > 4'd3);
      n          = illegal ? 0 : int'(si);
      e_pc  = 1'b1;
      e_if  = 1'b1;
      e_iff = 1'b0;
      e_idf = 1'b0;
      nhold = 0;
      if (rd) begin
         e_iff = 1'b1;
         e_idf = 1'b1;
      end else if (m_hold > 0) begin
         e_pc  = 1'b0;
         e_if  = 1'b0;
         e_idf = 1'b1;
         nhold = m_hold - 1;
      end else if (n > 0) begin
         e_pc  = 1'b0;
         e_if  = 1'b0;
         e_idf = 1'b1;
         nhold = n - 1;
      end
      @(negedge clk);
      chk("pc_we", 64'(pc_we), 64'(e_pc));
      chk("ifid_we", 64'(ifid_we), 64'(e_if));
      chk("ifid_flush", 64'(ifid_flush), 64'(e_iff));
      chk("idex_flush", 64'(idex_flush), 64'(e_idf));
      chk("stall_busy", 64'(stall_busy), 64'(m_hold > 0));
      chk("stall_left", 64'(stall_left), 64'(m_hold));
      chk("info_err", 64'(info_err), 64'(m_err));
      chk("perf_stall", 64'(perf_stall), 64'(m_pstall));
      chk("perf_flush", 64'(perf_flush), 64'(m_pflush));
      @(posedge clk);
      #1;
      m_hold = nhold;
      m_err  = m_err | illegal;
      if (!e_pc && m_pstall < perf_max) m_pstall++;
      if (e_iff && m_pflush < perf_max) m_pflush++;
   endtask

   initial begin
      int r;
      total    = 0;
      bad      = 0;
      perf_max = (longint'(1) << PERF_W) - 1;
      rst        = 1'b1;
      stall_info = 4'd0;
      redirect   = 1'b0;
      model_reset();

      do_reset(2);
      step(4'd0, 1'b0);
      chk("rst_perf_stall", 64'(perf_stall), 64'd0);
      chk("rst_busy", 64'(stall_busy), 64'd0);

      step(4'd3, 1'b0);
      chk("s3_left2", 64'(stall_left), 64'd2);
      step(4'd0, 1'b0);
      chk("s3_left1", 64'(stall_left), 64'd1);
      step(4'd0, 1'b0);
      chk("s3_left0", 64'(stall_left), 64'd0);
      step(4'd0, 1'b0);
      chk("s3_perf", 64'(perf_stall), 64'd3);

      step(4'd1, 1'b0);
      chk("s1_busy", 64'(stall_busy), 64'd0);
      step(4'd2, 1'b0);
      step(4'd0, 1'b0);
      step(4'd0, 1'b0);
      chk("s12_perf", 64'(perf_stall), 64'd6);

      step(4'd3, 1'b0);
      step(4'd0, 1'b1);
      chk("abort_left", 64'(stall_left), 64'd0);
      chk("abort_busy", 64'(stall_busy), 64'd0);
      step(4'd0, 1'b0);

      do_reset(1);
      step(4'd2, 1'b1);
      chk("rd2_flush", 64'(perf_flush), 64'd1);
      chk("rd2_stall", 64'(perf_stall), 64'd0);
      step(4'd0, 1'b0);

      step(4'hF, 1'b0);
      chk("err_set", 64'(info_err), 64'd1);
      step(4'd0, 1'b0);
      step(4'd3, 1'b0);
      step(4'd0, 1'b0);
      chk("err_hold", 64'(info_err), 64'd1);
      do_reset(1);
      chk("mid_rst_busy", 64'(stall_busy), 64'd0);
      chk("mid_rst_err", 64'(info_err), 64'd0);
      step(4'd0, 1'b0);

      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 7));
         step(4'(r > 3 ? 0 : r),
              ($urandom_range(0, 7) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
